// File: rtl/cfpu_pipe_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// cfpu_pipe_pkg : complex/float types, op encoding and single-precision FPU add/mult helpers
// Rev 1.0
// ----------------------------------------------------------------------------
package cfpu_pipe_pkg;

  typedef logic [31:0] floatType;

  typedef struct packed {
    floatType r;
    floatType i;
  } complex;

  typedef enum logic [1:0] {
    CFPU_ADD  = 2'd0,
    CFPU_SUB  = 2'd1,
    CFPU_MULT = 2'd2,
    CFPU_MAC  = 2'd3
  } cfpu_op_t;

  typedef struct packed {
    floatType r1;
    floatType r2;
    floatType i1;
    floatType i2;
  } terms_t;

  localparam int CX_W = $bits(complex);

  function automatic floatType fneg(input floatType a);
    return {~a[31], a[30:0]};
  endfunction

  // Denormals flush to zero, exponent 255 treated as infinity, round to nearest.
  function automatic floatType fp_mul(input floatType a, input floatType b);
    logic        s;
    logic [47:0] p;
    logic        inc;
    logic [24:0] r;
    int          e;
    s = a[31] ^ b[31];
    if (a[30:23] == 8'd0 || b[30:23] == 8'd0) return {s, 31'd0};
    if (a[30:23] == 8'hff || b[30:23] == 8'hff) return {s, 8'hff, 23'd0};
    p = 48'({1'b1, a[22:0]}) * 48'({1'b1, b[22:0]});
    e = int'(a[30:23]) + int'(b[30:23]) - 127;
    if (p[47]) e = e + 1;
    else p = p << 1;
    inc = p[23] & (p[24] | (|p[22:0]));
    r   = {1'b0, p[47:24]} + {24'd0, inc};
    if (r[24]) e = e + 1;
    if (e >= 255) return {s, 8'hff, 23'd0};
    if (e <= 0) return {s, 31'd0};
    return {s, e[7:0], r[22:0]};
  endfunction

  function automatic floatType fp_add(input floatType a, input floatType b);
    floatType    x;
    floatType    y;
    logic [27:0] mx;
    logic [27:0] my;
    logic [27:0] ms;
    logic [7:0]  d;
    logic        inc;
    logic [24:0] r;
    int          e;
    if (a[30:0] >= b[30:0]) begin
      x = a;
      y = b;
    end else begin
      x = b;
      y = a;
    end
    if (y[30:23] == 8'd0) return x;
    if (x[30:23] == 8'hff) return x;
    mx = {2'b01, x[22:0], 3'b000};
    my = {2'b01, y[22:0], 3'b000};
    d  = x[30:23] - y[30:23];
    my = (d > 8'd27) ? 28'd0 : (my >> d);
    ms = (x[31] == y[31]) ? (mx + my) : (mx - my);
    if (ms == 28'd0) return 32'h0;
    e = int'(x[30:23]);
    if (ms[27]) begin
      ms = ms >> 1;
      e  = e + 1;
    end else begin
      for (int k = 0; k < 26; k++) begin
        if (!ms[26]) begin
          ms = ms << 1;
          e  = e - 1;
        end
      end
    end
    inc = ms[2] & (ms[3] | ms[1] | ms[0]);
    r   = {1'b0, ms[26:3]} + {24'd0, inc};
    if (r[24]) e = e + 1;
    if (e >= 255) return {x[31], 8'hff, 23'd0};
    if (e <= 0) return {x[31], 31'd0};
    return {x[31], e[7:0], r[22:0]};
  endfunction

endpackage
`default_nettype wire

// File: rtl/cfpu_pipe_lane.sv
`default_nettype none
// ----------------------------------------------------------------------------
// cfpu_lane : one complex lane datapath - term stage, sum stage, output/accumulate stage
// Rev 1.0
// ----------------------------------------------------------------------------
module cfpu_lane
  import cfpu_pipe_pkg::*;
#(
  parameter int MUL_STAGES = 1,
  parameter int ADD_STAGES = 1
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     i_en,
  input  logic     i_acc_clr,
  input  logic     i_adv_o,
  input  cfpu_op_t i_op_t,
  input  cfpu_op_t i_op_o,
  input  complex   i_a,
  input  complex   i_b,
  output complex   o_result
);

  terms_t w_terms;
  terms_t r_t [MUL_STAGES];
  complex w_sum;
  complex r_s [ADD_STAGES];
  complex w_s;
  complex w_res;
  complex r_acc;
  complex r_result;

  always_comb begin
    w_terms = '0;
    case (i_op_t)
      CFPU_ADD: begin
        w_terms.r1 = i_a.r;
        w_terms.r2 = i_b.r;
        w_terms.i1 = i_a.i;
        w_terms.i2 = i_b.i;
      end
      CFPU_SUB: begin
        w_terms.r1 = i_a.r;
        w_terms.r2 = fneg(i_b.r);
        w_terms.i1 = i_a.i;
        w_terms.i2 = fneg(i_b.i);
      end
      default: begin
        w_terms.r1 = fp_mul(i_a.r, i_b.r);
        w_terms.r2 = fneg(fp_mul(i_a.i, i_b.i));
        w_terms.i1 = fp_mul(i_a.i, i_b.r);
        w_terms.i2 = fp_mul(i_a.r, i_b.i);
      end
    endcase
  end

  always_comb begin
    w_sum.r = fp_add(r_t[MUL_STAGES-1].r1, r_t[MUL_STAGES-1].r2);
    w_sum.i = fp_add(r_t[MUL_STAGES-1].i1, r_t[MUL_STAGES-1].i2);
  end

  // A clear coinciding with a MAC entering O restarts the sum from this beat.
  always_comb begin
    w_s   = r_s[ADD_STAGES-1];
    w_res = w_s;
    if (i_op_o == CFPU_MAC && !i_acc_clr) begin
      w_res.r = fp_add(r_acc.r, w_s.r);
      w_res.i = fp_add(r_acc.i, w_s.i);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < MUL_STAGES; k++) r_t[k] <= '0;
      for (int k = 0; k < ADD_STAGES; k++) r_s[k] <= '0;
      r_acc    <= '0;
      r_result <= '0;
    end else begin
      if (i_en) begin
        r_t[0] <= w_terms;
        for (int k = 1; k < MUL_STAGES; k++) r_t[k] <= r_t[k-1];
        r_s[0] <= w_sum;
        for (int k = 1; k < ADD_STAGES; k++) r_s[k] <= r_s[k-1];
        r_result <= w_res;
      end
      if (i_adv_o && i_op_o == CFPU_MAC) r_acc <= w_res;
      else if (i_acc_clr) r_acc <= '0;
    end
  end

  assign o_result = r_result;

endmodule
`default_nettype wire

// File: rtl/cfpu_pipe.sv
`default_nettype none
// ----------------------------------------------------------------------------
// cfpu_pipe : multi-lane pipelined complex FPU (ADD/SUB/MULT/MAC); CFPU_CONJ_EN adds conj_b
// Rev 1.0
// ----------------------------------------------------------------------------
module cfpu_pipe
  import cfpu_pipe_pkg::*;
#(
  parameter int LANES      = 1,
  parameter int MUL_STAGES = 1,
  parameter int ADD_STAGES = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  cfpu_op_t              op,
  input  logic [LANES*CX_W-1:0] A,
  input  logic [LANES*CX_W-1:0] B,
  input  logic                  acc_clr,
  output logic                  out_valid,
  input  logic                  out_ready,
`ifdef CFPU_CONJ_EN
  input  logic                  conj_b,
`endif
  output logic [LANES*CX_W-1:0] result
);

  localparam int LAT = MUL_STAGES + ADD_STAGES + 1;

  logic           w_en;
  logic           w_adv_o;
  logic [LAT-1:0] r_v;
  cfpu_op_t       r_op [LAT-1];

  assign w_en      = !out_valid || out_ready;
  assign in_ready  = w_en;
  assign out_valid = r_v[LAT-1];
  assign w_adv_o   = w_en && r_v[LAT-2];

  // Whole pipe advances or holds together; bubbles are never squeezed out.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_v <= '0;
      for (int k = 0; k < LAT - 1; k++) r_op[k] <= CFPU_ADD;
    end else if (w_en) begin
      r_v     <= {r_v[LAT-2:0], in_valid};
      r_op[0] <= op;
      for (int k = 1; k < LAT - 1; k++) r_op[k] <= r_op[k-1];
    end
  end

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    complex w_b_raw;
    complex w_b_lane;
    assign w_b_raw = B[k*CX_W +: CX_W];
`ifdef CFPU_CONJ_EN
    assign w_b_lane.r = w_b_raw.r;
    assign w_b_lane.i = conj_b ? fneg(w_b_raw.i) : w_b_raw.i;
`else
    assign w_b_lane = w_b_raw;
`endif

    cfpu_lane #(
      .MUL_STAGES(MUL_STAGES),
      .ADD_STAGES(ADD_STAGES)
    ) u_lane (
      .clk      (clk),
      .rst      (rst),
      .i_en     (w_en),
      .i_acc_clr(acc_clr),
      .i_adv_o  (w_adv_o),
      .i_op_t   (op),
      .i_op_o   (r_op[LAT-2]),
      .i_a      (A[k*CX_W +: CX_W]),
      .i_b      (w_b_lane),
      .o_result (result[k*CX_W +: CX_W])
    );
  end

endmodule
`default_nettype wire

// File: tb/tb_cfpu_pipe.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_cfpu_pipe : scoreboard bench for cfpu_pipe with two lanes
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_cfpu_pipe;
  import cfpu_pipe_pkg::*;

  localparam int LN  = 2;
  localparam int MS  = 1;
  localparam int AS  = 1;
  localparam int LAT = MS + AS + 1;
  localparam int W   = LN * CX_W;

  logic         clk       = 1'b0;
  logic         rst       = 1'b1;
  logic         in_valid  = 1'b0;
  logic         acc_clr   = 1'b0;
  logic         out_ready = 1'b1;
  cfpu_op_t     op        = CFPU_ADD;
  logic [W-1:0] A         = '0;
  logic [W-1:0] B         = '0;
  logic         in_ready;
  logic         out_valid;
  logic [W-1:0] result;
`ifdef CFPU_CONJ_EN
  logic         conj_b    = 1'b0;
`endif

  typedef struct {
    logic [W-1:0] res;
    int           acc_cyc;
    int           lat;
  } exp_t;

  exp_t q[$];
  int   cyc    = 0;
  int   n_chk  = 0;
  int   n_fail = 0;

  cfpu_pipe #(
    .LANES     (LN),
    .MUL_STAGES(MS),
    .ADD_STAGES(AS)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .op       (op),
    .A        (A),
    .B        (B),
    .acc_clr  (acc_clr),
    .out_valid(out_valid),
    .out_ready(out_ready),
`ifdef CFPU_CONJ_EN
    .conj_b   (conj_b),
`endif
    .result   (result)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Small exact values only: double -> single by rebiasing the exponent.
  function automatic logic [31:0] sp(input real r);
    logic [63:0] d;
    logic [10:0] e;
    if (r == 0.0) return 32'h0;
    d = $realtobits(r);
    e = d[62:52] - 11'd896;
    return {d[63], e[7:0], d[51:29]};
  endfunction

  function automatic logic [CX_W-1:0] cx(input real re, input real im);
    return {sp(re), sp(im)};
  endfunction

  task automatic send(input cfpu_op_t o, input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic clr, input logic [W-1:0] e, input bit sb, input int lat);
    bit   done;
    exp_t x;
    done = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b1; op = o; A = a; B = b; acc_clr = clr;
    for (int w = 0; w < 100 && !done; w++) begin
      @(negedge clk);
      if (in_ready) begin
        done = 1'b1;
        if (sb) begin
          x.res = e; x.acc_cyc = cyc; x.lat = lat;
          q.push_back(x);
        end
      end else begin
        @(posedge clk); #1;
      end
    end
    if (!done) check_eq("send_timeout", W'(0), W'(1));
  endtask

  task automatic idle();
    @(posedge clk); #1;
    in_valid = 1'b0;
    acc_clr  = 1'b0;
  endtask

  task automatic drain();
    for (int w = 0; w < 100 && q.size() > 0; w++) begin
      @(negedge clk); #1;
    end
    check_eq("drain", W'(q.size()), W'(0));
  endtask

  always @(negedge clk) begin
    if (!rst && out_valid) begin
      if (!out_ready) begin
        if (q.size() > 0) check_eq("stall_hold", result, q[0].res);
      end else if (q.size() == 0) begin
        check_eq("unexpected_out", W'(1), W'(0));
      end else begin
        exp_t x;
        x = q.pop_front();
        check_eq("result", result, x.res);
        if (x.lat >= 0) check_eq("latency", W'(cyc - x.acc_cyc), W'(x.lat));
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1);
  end

  initial begin
    int idx;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_eq("rst_out_valid", W'(out_valid), W'(0));
    check_eq("rst_result", result, '0);
    check_eq("rst_in_ready", W'(in_ready), W'(1));

    // ADD/SUB/MULT back to back, lane 1 carries different operands.
    send(CFPU_ADD,  {cx(2, 0), cx(1, 2)}, {cx(0, 3), cx(3, -1)}, 1'b0, {cx(2, 3),  cx(4, 1)},  1, LAT);
    send(CFPU_SUB,  {cx(2, 0), cx(1, 2)}, {cx(0, 3), cx(3, -1)}, 1'b0, {cx(2, -3), cx(-2, 3)}, 1, LAT);
    send(CFPU_MULT, {cx(2, 0), cx(1, 2)}, {cx(0, 3), cx(3, -1)}, 1'b0, {cx(0, 6),  cx(5, 5)},  1, LAT);
    send(CFPU_MAC,  {cx(2, 0), cx(1, 1)}, {cx(1, 1), cx(1, 0)},  1'b1, {cx(2, 2),  cx(1, 1)},  1, LAT);
    send(CFPU_MAC,  {cx(2, 0), cx(1, 1)}, {cx(1, 1), cx(1, 0)},  1'b0, {cx(4, 4),  cx(2, 2)},  1, LAT);
    send(CFPU_MAC,  {cx(2, 0), cx(1, 1)}, {cx(1, 1), cx(1, 0)},  1'b0, {cx(6, 6),  cx(3, 3)},  1, LAT);
    idle();
    drain();

    // Clear asserted exactly as the 4th MAC enters O: acc restarts from that beat.
    send(CFPU_MAC, {cx(2, 0), cx(1, 1)}, {cx(1, 1), cx(1, 0)}, 1'b0, {cx(2, 2), cx(1, 1)}, 1, LAT);
    idle();
    repeat (LAT - 2) @(posedge clk);
    #1 acc_clr = 1'b1;
    @(posedge clk); #1 acc_clr = 1'b0;
    send(CFPU_MAC, {cx(2, 0), cx(1, 1)}, {cx(1, 1), cx(1, 0)}, 1'b0, {cx(4, 4), cx(2, 2)}, 1, LAT);
    idle();
    drain();

    // Eight-beat burst with downstream stalled in burst cycles 4..6.
    idx = 0;
    for (int c = 0; c < 40 && idx < 8; c++) begin
      @(posedge clk); #1;
      out_ready = !(c >= 4 && c <= 6);
      in_valid  = 1'b1;
      op        = CFPU_ADD;
      acc_clr   = 1'b0;
      A = {cx(0, real'(idx + 1)), cx(real'(idx + 1), 0)};
      B = {cx(real'(idx + 1), 0), cx(1, 1)};
      @(negedge clk);
      check_eq("burst_in_ready", W'(in_ready), W'((c >= 4 && c <= 6) ? 0 : 1));
      if (in_ready) begin
        exp_t x;
        x.res = {cx(real'(idx + 1), real'(idx + 1)), cx(real'(idx + 2), 1)};
        x.acc_cyc = cyc;
        x.lat = -1;
        q.push_back(x);
        idx++;
      end
    end
    @(posedge clk); #1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    drain();

    // Reset with two MAC beats in flight: nothing emerges, acc restarts at zero.
    send(CFPU_MAC, {cx(2, 0), cx(1, 1)}, {cx(1, 1), cx(1, 0)}, 1'b0, '0, 0, LAT);
    send(CFPU_MAC, {cx(2, 0), cx(1, 1)}, {cx(1, 1), cx(1, 0)}, 1'b0, '0, 0, LAT);
    @(posedge clk); #1;
    in_valid = 1'b0;
    rst      = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    for (int c = 0; c < LAT + 2; c++) begin
      @(negedge clk);
      check_eq("rst_flush_valid", W'(out_valid), W'(0));
    end
    send(CFPU_MAC, {cx(2, 0), cx(1, 1)}, {cx(1, 1), cx(1, 0)}, 1'b0, {cx(2, 2), cx(1, 1)}, 1, LAT);
    idle();
    drain();

`ifdef CFPU_CONJ_EN
    @(posedge clk); #1 conj_b = 1'b1;
    send(CFPU_MULT, {cx(2, 0), cx(1, 2)}, {cx(0, 3), cx(3, 1)}, 1'b0, {cx(0, -6), cx(5, 5)}, 1, LAT);
    idle();
    conj_b = 1'b0;
    drain();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
